// File: rtl/lock_sequencer.sv
// Central sequencer for the 4-switch combination lock: stores the key, tracks
// the attempt budget and the per-second countdown, and reports unset/armed/open/alert.
// Ports: clk/rst (async active-high), sw key switches, set_btn/cmp_btn request
// levels (edge-detected here); BCD tries_left/secs_left plus open/locked/alert/key_valid flags.
// Every output is registered, so actions become visible one cycle after the button edge.
module lock_sequencer #(
  parameter int TICK_DIV  = 100000000,
  parameter int MAX_TRIES = 5,
  parameter int TIMEOUT_S = 9,
  parameter int OPEN_S    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       set_btn,
  input  logic       cmp_btn,
  output logic [3:0] tries_left,
  output logic [3:0] secs_left,
  output logic       open,
  output logic       locked,
  output logic       alert,
  output logic       key_valid
);

  typedef enum logic [1:0] {
    S_UNSET = 2'd0,
    S_ARMED = 2'd1,
    S_OPEN  = 2'd2,
    S_ALERT = 2'd3
  } state_t;

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [3:0]    ARMED_SECS = 4'(TIMEOUT_S);
  localparam logic [3:0]    OPEN_SECS  = 4'(OPEN_S);

  state_t        state, state_nxt;
  logic [3:0]    key, key_nxt;
  logic [3:0]    tries_nxt, secs_nxt;
  logic          key_valid_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          set_q, cmp_q;
  logic          set_p, cmp_p, tick;
  logic          open_nxt, locked_nxt, alert_nxt;

  assign set_p = set_btn & ~set_q;
  assign cmp_p = cmp_btn & ~cmp_q;
  // The one-second prescaler only runs while a countdown is active.
  assign tick  = ((state == S_ARMED) || (state == S_OPEN)) && (presc == PRE_LAST);

  // State register together with the datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_UNSET;
      key        <= 4'd0;
      tries_left <= TRIES_INIT;
      secs_left  <= ARMED_SECS;
      key_valid  <= 1'b0;
      presc      <= '0;
      set_q      <= 1'b0;
      cmp_q      <= 1'b0;
      open       <= 1'b0;
      locked     <= 1'b1;
      alert      <= 1'b0;
    end else begin
      state      <= state_nxt;
      key        <= key_nxt;
      tries_left <= tries_nxt;
      secs_left  <= secs_nxt;
      key_valid  <= key_valid_nxt;
      presc      <= presc_nxt;
      set_q      <= set_btn;
      cmp_q      <= cmp_btn;
      open       <= open_nxt;
      locked     <= locked_nxt;
      alert      <= alert_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    key_nxt       = key;
    tries_nxt     = tries_left;
    secs_nxt      = secs_left;
    key_valid_nxt = key_valid;

    case (state)
      S_UNSET: begin
        if (set_p) begin
          key_nxt       = sw;
          key_valid_nxt = 1'b1;
          tries_nxt     = TRIES_INIT;
          secs_nxt      = ARMED_SECS;
          state_nxt     = S_ARMED;
        end
      end
      S_ARMED: begin
        // A correct compare pre-empts any tick on the same edge; set is ignored.
        if (cmp_p && (sw == key)) begin
          tries_nxt = TRIES_INIT;
          secs_nxt  = OPEN_SECS;
          state_nxt = S_OPEN;
        end else begin
          // Wrong guess and tick may land together; both decrements apply.
          if (cmp_p && (tries_left != 4'd0)) tries_nxt = tries_left - 4'd1;
          if (tick && (secs_left != 4'd0))   secs_nxt  = secs_left - 4'd1;
          // Zero is only reachable through one of the decrements above.
          if ((tries_nxt == 4'd0) || (secs_nxt == 4'd0)) state_nxt = S_ALERT;
        end
      end
      S_OPEN: begin
        if (set_p) begin
          key_nxt   = sw;
          tries_nxt = TRIES_INIT;
          secs_nxt  = ARMED_SECS;
          state_nxt = S_ARMED;
        end else if (tick) begin
          if (secs_left <= 4'd1) begin
            secs_nxt  = ARMED_SECS;
            state_nxt = S_ARMED;
          end else begin
            secs_nxt = secs_left - 4'd1;
          end
        end
      end
      default: begin
        // Alert holds everything until reset.
      end
    endcase

    // Prescaler restarts on every state entry so each state gets full seconds.
    if (state_nxt != state) begin
      presc_nxt = '0;
    end else if ((state == S_ARMED) || (state == S_OPEN)) begin
      presc_nxt = tick ? '0 : presc + 1'b1;
    end else begin
      presc_nxt = '0;
    end
  end

  // Output decode from the next state, captured by the register process.
  always_comb begin
    open_nxt   = (state_nxt == S_OPEN);
    locked_nxt = ~open_nxt;
    alert_nxt  = (state_nxt == S_ALERT);
  end

endmodule
